// File: rtl/servo_pwm_pkg.sv
// Shared constants for the servo PWM slave: register indices, CTRL bit positions, AXI response code.
package servo_pwm_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PULSE_A = 2'd2;
  localparam logic [1:0] REG_PULSE_B = 2'd3;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_EN_A = 1;
  localparam int CTRL_EN_B = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Two-channel servo PWM: free-running period counter, shadowed PERIOD/PULSE, registered compare.
// Outputs lag the counter by one cycle; settings change only at period boundaries or on run start.
module servo_pwm_gen
  import servo_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        en_a,
  input  logic        en_b,
  input  logic [31:0] period,
  input  logic [31:0] pulse_a,
  input  logic [31:0] pulse_b,
  output logic        pwm_a,
  output logic        pwm_b
);

  logic        run_q;
  logic [31:0] cnt;
  logic [31:0] sh_period;
  logic [31:0] sh_pulse_a;
  logic [31:0] sh_pulse_b;

  logic        run_rise;
  logic        at_end;
  logic        reload;
  logic [31:0] eff_period;
  logic [31:0] eff_pulse_a;
  logic [31:0] eff_pulse_b;

  // On the first running cycle the shadows are still stale, so use the live values directly.
  always_comb begin
    run_rise    = run & ~run_q;
    eff_period  = run_rise ? period  : sh_period;
    eff_pulse_a = run_rise ? pulse_a : sh_pulse_a;
    eff_pulse_b = run_rise ? pulse_b : sh_pulse_b;
    at_end      = (eff_period == 32'd0) || (cnt >= eff_period - 32'd1);
    reload      = run & (run_rise | at_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      cnt        <= '0;
      sh_period  <= '0;
      sh_pulse_a <= '0;
      sh_pulse_b <= '0;
      pwm_a      <= 1'b0;
      pwm_b      <= 1'b0;
    end else begin
      run_q <= run;
      if (!run || at_end) cnt <= '0;
      else                cnt <= cnt + 32'd1;
      if (reload) begin
        sh_period  <= period;
        sh_pulse_a <= pulse_a;
        sh_pulse_b <= pulse_b;
      end
      pwm_a <= run & en_a & (cnt < eff_pulse_a);
      pwm_b <= run & en_b & (cnt < eff_pulse_b);
    end
  end

endmodule

// File: rtl/servo_pwm_axi_slave.sv
// AXI4-Lite register file (CTRL, PERIOD, PULSE_A, PULSE_B) driving a two-channel servo PWM generator.
// Registered one-cycle ready pulses; one write and one read outstanding, responses held until accepted.
module servo_pwm_axi_slave
  import servo_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
)(
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_a,
  output logic                            pwm_b
);

  logic [1:0]  rst_sync;
  logic        rst_n;
  logic        wr_rdy;
  logic        rd_rdy;
  logic        wr_hs;
  logic        rd_hs;
  logic [1:0]  wr_idx;
  logic [1:0]  rd_idx;
  logic [31:0] ctrl;
  logic [31:0] period;
  logic [31:0] pulse_a;
  logic [31:0] pulse_b;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rst_sync <= 2'b00;
    else                rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];
  assign wr_hs  = wr_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs  = rd_rdy & S_AXI_ARVALID;

  assign S_AXI_AWREADY = wr_rdy;
  assign S_AXI_WREADY  = wr_rdy;
  assign S_AXI_ARREADY = rd_rdy;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;

  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_rdy       <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      ctrl         <= '0;
      period       <= '0;
      pulse_a      <= '0;
      pulse_b      <= '0;
    end else begin
      wr_rdy <= ~wr_rdy & S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID;
      if (wr_hs)             S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (wr_hs) begin
        case (wr_idx)
          REG_CTRL:    ctrl    <= apply_strb(ctrl,    S_AXI_WDATA, S_AXI_WSTRB);
          REG_PERIOD:  period  <= apply_strb(period,  S_AXI_WDATA, S_AXI_WSTRB);
          REG_PULSE_A: pulse_a <= apply_strb(pulse_a, S_AXI_WDATA, S_AXI_WSTRB);
          REG_PULSE_B: pulse_b <= apply_strb(pulse_b, S_AXI_WDATA, S_AXI_WSTRB);
          default:     ctrl    <= ctrl;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      REG_CTRL:    rd_mux = ctrl;
      REG_PERIOD:  rd_mux = period;
      REG_PULSE_A: rd_mux = pulse_a;
      REG_PULSE_B: rd_mux = pulse_b;
      default:     rd_mux = '0;
    endcase
  end

  // rd_mux samples pre-edge register values, so a same-cycle write is not visible to this read.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_rdy       <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else begin
      rd_rdy <= ~rd_rdy & S_AXI_ARVALID & ~S_AXI_RVALID;
      if (rd_hs) begin
        S_AXI_RDATA  <= rd_mux;
        S_AXI_RVALID <= 1'b1;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  servo_pwm_gen u_gen (
    .clk     (S_AXI_ACLK),
    .rst_n   (rst_n),
    .run     (ctrl[CTRL_RUN]),
    .en_a    (ctrl[CTRL_EN_A]),
    .en_b    (ctrl[CTRL_EN_B]),
    .period  (period),
    .pulse_a (pulse_a),
    .pulse_b (pulse_b),
    .pwm_a   (pwm_a),
    .pwm_b   (pwm_b)
  );

endmodule

// File: tb/tb_servo_pwm_axi_slave.sv
// Scoreboard bench: stimulus queues expected B/R responses and PWM run lengths; monitors pop and compare.
module tb_servo_pwm_axi_slave;

  logic        S_AXI_ACLK    = 1'b0;
  logic        S_AXI_ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR  = '0;
  logic [2:0]  S_AXI_AWPROT  = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA   = '0;
  logic [3:0]  S_AXI_WSTRB   = '0;
  logic        S_AXI_WVALID  = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY  = 1'b1;
  logic [3:0]  S_AXI_ARADDR  = '0;
  logic [2:0]  S_AXI_ARPROT  = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY  = 1'b1;
  logic        pwm_a;
  logic        pwm_b;

  servo_pwm_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .pwm_a(pwm_a), .pwm_b(pwm_b)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] r_q[$];
  logic [1:0]  b_q[$];
  int          hi_q[$];
  int          lo_q[$];
  bit          pmon_en = 1'b0;
  int          pb_hi = 0;
  int          aw_hs = 0;
  logic        pa_prev = 1'b0;
  int          pa_len = 0;
  bit          pa_fall_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  // Write/read response scoreboard and write-accept counter
  always @(negedge S_AXI_ACLK) begin
    if (S_AXI_AWREADY && S_AXI_AWVALID) aw_hs++;
    if (S_AXI_BVALID && S_AXI_BREADY) begin
      if (b_q.size() == 0) timeout("bvalid_unexpected");
      else chk("bresp", 32'(S_AXI_BRESP), 32'(b_q.pop_front()));
    end
    if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (r_q.size() == 0) timeout("rvalid_unexpected");
      else begin
        chk("rdata", S_AXI_RDATA, r_q.pop_front());
        chk("rresp", 32'(S_AXI_RRESP), 32'd0);
      end
    end
  end

  // PWM run-length monitor: high lengths at each fall, low lengths at each rise after a fall
  always @(negedge S_AXI_ACLK) begin
    if (!pmon_en) begin
      pa_prev = pwm_a;
      pa_len = 0;
      pa_fall_seen = 1'b0;
    end else begin
      if (pwm_b) pb_hi++;
      if (pwm_a !== pa_prev) begin
        if (pa_prev) begin
          if (hi_q.size() == 0) timeout("pwm_a_high_unexpected");
          else chk("pwm_a_high_len", 32'(pa_len), 32'(hi_q.pop_front()));
          pa_fall_seen = 1'b1;
        end else if (pa_fall_seen) begin
          if (lo_q.size() == 0) timeout("pwm_a_low_unexpected");
          else chk("pwm_a_low_len", 32'(pa_len), 32'(lo_q.pop_front()));
        end
        pa_len = 1;
      end else begin
        pa_len++;
      end
      pa_prev = pwm_a;
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    b_q.push_back(2'b00);
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_AWREADY && n < 50);
    if (!S_AXI_AWREADY) timeout("write_accept");
    @(posedge S_AXI_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    int n;
    n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    r_q.push_back(exp);
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_ARREADY && n < 50);
    if (!S_AXI_ARREADY) timeout("read_accept");
    @(posedge S_AXI_ACLK); #1;
    S_AXI_ARVALID = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_a, cnt_b, hs0, early, extra;
    logic [31:0] exp_rd [4];

    // Reset state
    repeat (3) @(negedge S_AXI_ACLK);
    chk("reset_ctrl_outs", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, pwm_a, pwm_b}), 32'd0);
    chk("reset_rdata", S_AXI_RDATA, 32'd0);
    @(posedge S_AXI_ACLK); #1 S_AXI_ARESETN = 1'b1;
    repeat (4) @(posedge S_AXI_ACLK); #1;

    // Basic write/readback
    exp_rd[0] = 32'd1; exp_rd[1] = 32'd2; exp_rd[2] = 32'd3; exp_rd[3] = 32'd4;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), exp_rd[i], 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), exp_rd[i]);
    axi_write(4'h0, 32'd0, 4'hF);

    // Byte strobes, and an all-zero strobe
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
    axi_read(4'h4, 32'h0000CC00);
    axi_write(4'hC, 32'hFFFFFFFF, 4'b0000);
    axi_read(4'hC, 32'd4);

    // AW leads W by 3 cycles, BREADY held low: single accept, BVALID held, no second accept
    S_AXI_BREADY = 1'b0;
    hs0 = aw_hs;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'd77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1;
    early = 0;
    repeat (3) begin @(negedge S_AXI_ACLK); if (S_AXI_AWREADY || S_AXI_WREADY) early++; end
    chk("aw_without_w_not_accepted", 32'(early), 32'd0);
    @(posedge S_AXI_ACLK); #1 S_AXI_WVALID = 1'b1;
    b_q.push_back(2'b00);
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_AWREADY && n < 50);
    if (!S_AXI_AWREADY) timeout("late_w_accept");
    @(posedge S_AXI_ACLK); #1 S_AXI_WDATA = 32'd99;
    extra = 0;
    repeat (5) begin
      @(negedge S_AXI_ACLK);
      chk("bvalid_held", 32'(S_AXI_BVALID), 32'd1);
      if (S_AXI_AWREADY) extra++;
    end
    chk("no_accept_while_bvalid", 32'(extra), 32'd0);
    chk("single_accept", 32'(aw_hs - hs0), 32'd1);
    @(posedge S_AXI_ACLK); #1 S_AXI_BREADY = 1'b1;
    b_q.push_back(2'b00);
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_AWREADY && n < 50);
    if (!S_AXI_AWREADY) timeout("second_accept");
    @(posedge S_AXI_ACLK); #1 S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    axi_read(4'h4, 32'd99);

    // Simultaneous read and write of PULSE_B: read sees the old value
    repeat (3) @(posedge S_AXI_ACLK); #1;
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1;
    b_q.push_back(2'b00);
    r_q.push_back(32'd4);
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_AWREADY && n < 50);
    chk("simul_arready", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    repeat (2) @(posedge S_AXI_ACLK); #1;
    axi_read(4'hC, 32'h55);

    // PWM: period 100, pulse 25, then 50 written mid-period
    axi_write(4'h0, 32'd0, 4'hF);
    axi_write(4'h4, 32'd100, 4'hF);
    axi_write(4'h8, 32'd25, 4'hF);
    axi_write(4'hC, 32'd10, 4'hF);
    hi_q = '{25, 50, 50};
    lo_q = '{75, 50};
    pb_hi = 0;
    pmon_en = 1'b1;
    axi_write(4'h0, 32'h3, 4'hF);
    repeat (40) @(posedge S_AXI_ACLK); #1;
    axi_write(4'h8, 32'd50, 4'hF);
    repeat (230) @(posedge S_AXI_ACLK); #1;
    pmon_en = 1'b0;
    chk("pwm_a_high_left", 32'(hi_q.size()), 32'd0);
    chk("pwm_a_low_left", 32'(lo_q.size()), 32'd0);
    chk("pwm_b_disabled_highs", 32'(pb_hi), 32'd0);

    // Boundaries: PULSE_A=0 constantly low, PULSE_B >= PERIOD constantly high
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'hC, 32'd200, 4'hF);
    axi_write(4'h0, 32'h7, 4'hF);
    repeat (120) @(posedge S_AXI_ACLK);
    cnt_a = 0; cnt_b = 0;
    repeat (150) begin
      @(negedge S_AXI_ACLK);
      if (pwm_a) cnt_a++;
      if (!pwm_b) cnt_b++;
    end
    chk("pulse0_a_highs", 32'(cnt_a), 32'd0);
    chk("pulse_ge_period_b_lows", 32'(cnt_b), 32'd0);

    // Clearing run: outputs low one cycle after run drops
    @(posedge S_AXI_ACLK); #1;
    axi_write(4'h0, 32'h6, 4'hF);
    @(negedge S_AXI_ACLK);
    chk("pwm_b_before_stop", 32'(pwm_b), 32'd1);
    @(negedge S_AXI_ACLK);
    chk("pwm_b_after_stop", 32'(pwm_b), 32'd0);
    chk("pwm_a_after_stop", 32'(pwm_a), 32'd0);

    // Reset while a read response is pending and PWM is running
    @(posedge S_AXI_ACLK); #1;
    axi_write(4'h8, 32'd60, 4'hF);
    axi_write(4'h0, 32'h3, 4'hF);
    repeat (10) @(posedge S_AXI_ACLK); #1;
    @(negedge S_AXI_ACLK);
    chk("pwm_a_running", 32'(pwm_a), 32'd1);
    @(posedge S_AXI_ACLK); #1;
    S_AXI_RREADY = 1'b0;
    r_q.push_back(32'd100);
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge S_AXI_ACLK); n++; end while (!S_AXI_ARREADY && n < 50);
    @(posedge S_AXI_ACLK); #1 S_AXI_ARVALID = 1'b0;
    repeat (3) begin
      @(negedge S_AXI_ACLK);
      chk("rvalid_pending", 32'(S_AXI_RVALID), 32'd1);
      chk("rdata_stable", S_AXI_RDATA, 32'd100);
    end
    @(posedge S_AXI_ACLK); #3 S_AXI_ARESETN = 1'b0;
    r_q.delete();
    #1;
    chk("arst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("arst_rdata", S_AXI_RDATA, 32'd0);
    chk("arst_pwm", 32'({pwm_a, pwm_b}), 32'd0);
    chk("arst_handshake", 32'({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_BVALID}), 32'd0);
    repeat (3) @(posedge S_AXI_ACLK); #1 S_AXI_ARESETN = 1'b1;
    repeat (4) @(posedge S_AXI_ACLK); #1 S_AXI_RREADY = 1'b1;
    @(negedge S_AXI_ACLK);
    chk("post_reset_rvalid", 32'(S_AXI_RVALID), 32'd0);
    @(posedge S_AXI_ACLK); #1;
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'd0);
    repeat (5) @(negedge S_AXI_ACLK);
    chk("post_reset_pwm", 32'({pwm_a, pwm_b}), 32'd0);

    repeat (5) @(negedge S_AXI_ACLK);
    chk("b_queue_drained", 32'(b_q.size()), 32'd0);
    chk("r_queue_drained", 32'(r_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_axi_slave.md
SERVO_PWM_AXI_SLAVE -- requirements
Module: servo_pwm_axi_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; covers 4 word registers.
REQ-003 S_AXI_ACLK  in  1  single clock for all logic.
REQ-004 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 S_AXI_AWADDR  in  4, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-006 S_AXI_WDATA  in  32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 S_AXI_BRESP  out  2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 S_AXI_ARADDR  in  4, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-009 S_AXI_RDATA  out  32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-010 pwm_a, pwm_b  out  1 each: servo pulse outputs.

Function
REQ-011 Register map, word index = AWADDR/ARADDR[3:2]: 0 CTRL (bit0 run, bit1 en_a, bit2 en_b), 1 PERIOD, 2 PULSE_A, 3 PULSE_B; all 32 bits stored and read back exactly as written.
REQ-012 Write accept: when AWVALID and WVALID both high and BVALID low, AWREADY and WREADY pulse high together for exactly one cycle; register updates on that edge.
REQ-013 WSTRB[n] high updates byte n only; WSTRB=0 completes the handshake with no register change.
REQ-014 BVALID rises the cycle after the write handshake, BRESP=2'b00, held until BREADY sampled high; no new write is accepted while BVALID is high.
REQ-015 AWVALID without WVALID (or vice versa) is not accepted; the slave waits for both.
REQ-016 Read accept: when ARVALID high and RVALID low, ARREADY pulses one cycle; RDATA/RVALID valid next cycle, RRESP=2'b00, RDATA stable until RREADY sampled high.
REQ-017 Simultaneous read and write handshakes in one cycle both proceed; a read of the register being written in the same cycle returns the old value.
REQ-018 PWM counter: 32-bit, counts 0..PERIOD-1 and wraps to 0 when CTRL.run=1 and PERIOD!=0; otherwise held at 0.
REQ-019 Shadow registers for PERIOD, PULSE_A, PULSE_B load from the live registers when counter wraps to 0 and when run transitions 0->1; mid-period writes take effect at the next period only.
REQ-020 pwm_x = run & en_x & (counter < shadow PULSE_x), registered (one-cycle latency from counter).
REQ-021 PULSE_x=0 -> pwm_x constantly low; PULSE_x >= PERIOD -> pwm_x constantly high while running.
REQ-022 Clearing run drives both outputs low on the next cycle and holds counter at 0.

Reset
REQ-023 ARESETN low asynchronously clears all registers, shadows, counter, pwm_a, pwm_b, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA to 0.
REQ-024 Reset mid-transaction aborts it; after release the slave accepts fresh transactions with no stale BVALID/RVALID.
REQ-025 Reset release is synchronous to S_AXI_ACLK for internal logic (two-flop deassert synchronizer).

Structure
REQ-026 Shared package servo_pwm_pkg holds register index constants, CTRL bit positions, and the OKAY response constant.
REQ-027 One sub-module servo_pwm_gen (counter, shadows, compare for both channels); AXI register file in the top module.

Verification
REQ-028 Write 1,2,3,4 to offsets 0x0,0x4,0x8,0xC, read back -> 0x1,0x2,0x3,0x4, all BRESP/RRESP OKAY.
REQ-029 PERIOD=100, PULSE_A=25, CTRL=0x3 -> pwm_a high 25 cycles, low 75, repeating; pwm_b low.
REQ-030 Write PULSE_A=50 mid-period -> current period keeps 25-cycle pulse; next period 50.
REQ-031 WSTRB=4'b0010, WDATA=0xAABBCCDD to PERIOD holding 0 -> readback 0x0000CC00.
REQ-032 AWVALID asserted 3 cycles before WVALID with BREADY held low 5 cycles -> single AWREADY/WREADY pulse, BVALID held until BREADY, no second accept.
REQ-033 Assert ARESETN low while RVALID pending and PWM running -> RVALID, pwm_a, pwm_b, all registers 0; subsequent readback 0x0.
